// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline hazard controller.
//   - ctrl_state_e : memory-wait FSM encoding (RUN / WAIT / ERR)
//   - PC_REG_IDX   : register index of the PC, never treated as a data dependency
//   - DEF_*        : default parameter values for the controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } ctrl_state_e;

  localparam logic [3:0] PC_REG_IDX = 4'd15;

  localparam int DEF_REG_ADDR_W  = 4;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational read-after-write detection between the ID-stage
// sources and the EXE / MEM destinations.
// Build option: FORWARDING_EN
//   defined   - results are forwarded, only a load in EXE (load-use) stalls
//   undefined - any EXE or MEM write to a source register stalls
// Ports:
//   id_src1/2, id_use_src1/2 : ID-stage sources and their use bits
//   exe_wb_en, exe_dest      : EXE write-back enable and destination
//   exe_mem_read             : EXE instruction is a load
//   mem_wb_en, mem_dest      : MEM write-back enable and destination
//   raw_hazard               : ID instruction must wait
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  exe_wb_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_mem_read,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  raw_hazard
);

  localparam logic [REG_ADDR_W-1:0] PC_IDX = REG_ADDR_W'(PC_REG_IDX);

  // The PC is read from the fetch path, so writing it never creates a RAW hazard.
  function automatic logic src_hit(input logic                  use_bit,
                                   input logic                  wb_en,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dst);
    return use_bit & wb_en & (src == dst) & (src != PC_IDX);
  endfunction

  logic exe_hit;

  // Match against the EXE destination; shared by both build options.
  always_comb begin
    exe_hit = src_hit(id_use_src1, exe_wb_en, id_src1, exe_dest) |
              src_hit(id_use_src2, exe_wb_en, id_src2, exe_dest);
  end

`ifdef FORWARDING_EN
  // With forwarding only a load result is unavailable to the next instruction.
  always_comb begin
    raw_hazard = exe_hit & exe_mem_read;
  end
`else
  logic mem_hit;

  // Without forwarding, loads and ALU results alike must reach write-back first.
  always_comb begin
    mem_hit    = src_hit(id_use_src1, mem_wb_en, id_src1, mem_dest) |
                 src_hit(id_use_src2, mem_wb_en, id_src2, mem_dest);
    raw_hazard = (exe_hit & exe_mem_read) | (exe_hit & ~exe_mem_read) | mem_hit;
  end
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central stall / flush controller of the 5-stage core.
// Build option: FORWARDING_EN (selects load-use-only stalling in hazard_detect).
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   id_* / exe_* / mem_* : hazard-detection inputs (see hazard_detect)
//   mem_req, sram_ready  : data-memory access in progress / completing this cycle
//   branch_taken         : EXE resolved a taken branch
//   freeze_if, flush_if  : hold / clear PC and IF stage register
//   id_bubble            : zero ID/EX control fields
//   freeze_pipe          : hold ID/EX, EXE/MEM, MEM/WB during a memory wait
//   mem_timeout          : sticky memory timeout (left only by reset)
//   stall_cycles         : saturating count of frozen cycles
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_use_src1,
  input  logic                  id_use_src2,
  input  logic                  exe_wb_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_mem_read,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_req,
  input  logic                  sram_ready,
  input  logic                  branch_taken,
  output logic                  freeze_if,
  output logic                  flush_if,
  output logic                  id_bubble,
  output logic                  freeze_pipe,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic              mem_frozen;
  logic              raw_hazard;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_use_src1  (id_use_src1),
    .id_use_src2  (id_use_src2),
    .exe_wb_en    (exe_wb_en),
    .exe_dest     (exe_dest),
    .exe_mem_read (exe_mem_read),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .raw_hazard   (raw_hazard)
  );

  // Memory-wait FSM: freezes in the request cycle and releases in the ready cycle.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_frozen = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !sram_ready) begin
          mem_frozen = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = {WCNT_W{1'b0}};
        end else begin
          wait_cnt_d = {WCNT_W{1'b0}};
        end
      end
      WAIT: begin
        if (sram_ready) begin
          state_d    = RUN;
          wait_cnt_d = {WCNT_W{1'b0}};
        end else if (wait_cnt_q == WCNT_LAST) begin
          mem_frozen = 1'b1;
          state_d    = ERR;
          wait_cnt_d = wait_cnt_q + WCNT_ONE;
        end else begin
          mem_frozen = 1'b1;
          wait_cnt_d = wait_cnt_q + WCNT_ONE;
        end
      end
      ERR: begin
        mem_frozen = 1'b1;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = {WCNT_W{1'b0}};
      end
    endcase
  end

  // Output priority: memory freeze, then branch flush, then data-hazard stall.
  // A branch beats the data stall because the stalled instruction is discarded.
  always_comb begin
    freeze_if   = 1'b0;
    flush_if    = 1'b0;
    id_bubble   = 1'b0;
    freeze_pipe = 1'b0;
    if (!rst) begin
      freeze_if = 1'b0;
    end else if (mem_frozen) begin
      freeze_pipe = 1'b1;
      freeze_if   = 1'b1;
    end else if (branch_taken || flush_pend_q) begin
      flush_if  = 1'b1;
      id_bubble = 1'b1;
    end else if (raw_hazard) begin
      freeze_if = 1'b1;
      id_bubble = 1'b1;
    end else begin
      freeze_if = 1'b0;
    end
  end

  // A branch seen while frozen is remembered until the first unfrozen cycle.
  always_comb begin
    if (mem_frozen) begin
      flush_pend_d = flush_pend_q | branch_taken;
    end else begin
      flush_pend_d = 1'b0;
    end
  end

  // Saturating stall counter.
  always_comb begin
    if ((freeze_if || freeze_pipe) && (stall_cycles_q != CNT_MAX)) begin
      stall_cycles_d = stall_cycles_q + CNT_ONE;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= {WCNT_W{1'b0}};
      flush_pend_q   <= 1'b0;
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      flush_pend_q   <= flush_pend_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_timeout  = (state_q == ERR);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Two instances share the inputs:
// dut_a uses default parameters, dut_b uses TIMEOUT_CYC=4 and CNT_W=3.
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_use_src1, id_use_src2, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       mem_req, sram_ready, branch_taken;

  logic        freeze_if_a, flush_if_a, id_bubble_a, freeze_pipe_a, mem_timeout_a;
  logic [15:0] stall_cycles_a;
  logic        freeze_if_b, flush_if_b, id_bubble_b, freeze_pipe_b, mem_timeout_b;
  logic [2:0]  stall_cycles_b;

  int n_tests;
  int n_fail;

  // Expected bubbles for a non-load dependency and for a load moving into MEM.
  logic       e_alu;
  logic [31:0] e_cnt_alu;
  logic [31:0] e_cnt_load;

  pipeline_hazard_ctrl dut_a (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mem_req(mem_req), .sram_ready(sram_ready), .branch_taken(branch_taken),
    .freeze_if(freeze_if_a), .flush_if(flush_if_a), .id_bubble(id_bubble_a),
    .freeze_pipe(freeze_pipe_a), .mem_timeout(mem_timeout_a),
    .stall_cycles(stall_cycles_a)
  );

  pipeline_hazard_ctrl #(.TIMEOUT_CYC(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .exe_wb_en(exe_wb_en), .exe_dest(exe_dest), .exe_mem_read(exe_mem_read),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .mem_req(mem_req), .sram_ready(sram_ready), .branch_taken(branch_taken),
    .freeze_if(freeze_if_b), .flush_if(flush_if_b), .id_bubble(id_bubble_b),
    .freeze_pipe(freeze_pipe_b), .mem_timeout(mem_timeout_b),
    .stall_cycles(stall_cycles_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    exe_wb_en = 1'b0; exe_dest = 4'd0; exe_mem_read = 1'b0;
    mem_wb_en = 1'b0; mem_dest = 4'd0;
    mem_req = 1'b0; sram_ready = 1'b0; branch_taken = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
`ifdef FORWARDING_EN
    e_alu      = 1'b0;
    e_cnt_alu  = 32'd0;
    e_cnt_load = 32'd1;
`else
    e_alu      = 1'b1;
    e_cnt_alu  = 32'd2;
    e_cnt_load = 32'd4;
`endif

    // Reset: outputs held low even with a hazard and a memory wait on the inputs.
    rst = 1'b0;
    idle();
    id_src1 = 4'd2; id_use_src1 = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd2;
    mem_req = 1'b1;
    #2;
    chk("rst_freeze_if", freeze_if_a, 32'd0);
    chk("rst_freeze_pipe", freeze_pipe_a, 32'd0);
    chk("rst_bubble", id_bubble_a, 32'd0);
    chk("rst_stall_cnt", stall_cycles_a, 32'd0);
    chk("rst_timeout", mem_timeout_a, 32'd0);
    tick();
    rst = 1'b1;
    idle();

    // RAW on R2: instruction in EXE, then in MEM.
    do_reset();
    id_src1 = 4'd2; id_use_src1 = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd2;
    #2;
    chk("raw_exe_freeze_if", freeze_if_a, 32'(e_alu));
    chk("raw_exe_bubble", id_bubble_a, 32'(e_alu));
    chk("raw_exe_freeze_pipe", freeze_pipe_a, 32'd0);
    chk("raw_exe_flush", flush_if_a, 32'd0);
    tick();
    exe_wb_en = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd2;
    #2;
    chk("raw_mem_freeze_if", freeze_if_a, 32'(e_alu));
    tick();
    idle();
    #2;
    chk("raw_clear_freeze_if", freeze_if_a, 32'd0);
    chk("raw_stall_cnt", stall_cycles_a, e_cnt_alu);

    // Load-use on R2: one bubble with forwarding, two without.
    id_src1 = 4'd2; id_use_src1 = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd2; exe_mem_read = 1'b1;
    #2;
    chk("load_exe_freeze_if", freeze_if_a, 32'd1);
    tick();
    exe_wb_en = 1'b0; exe_mem_read = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd2;
    #2;
    chk("load_mem_freeze_if", freeze_if_a, 32'(e_alu));
    tick();
    idle();
    #2;
    chk("load_stall_cnt", stall_cycles_a, e_cnt_load);

    // src2 path, and the use bit gating it.
    id_src2 = 4'd7; id_use_src2 = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd7; exe_mem_read = 1'b1;
    #2;
    chk("src2_hit", freeze_if_a, 32'd1);
    id_use_src2 = 1'b0;
    #1;
    chk("src2_unused", freeze_if_a, 32'd0);
    idle();

    // The PC never matches.
    id_src1 = 4'd15; id_use_src1 = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd15; exe_mem_read = 1'b1;
    mem_wb_en = 1'b1; mem_dest = 4'd15;
    #2;
    chk("pc_no_stall", freeze_if_a, 32'd0);
    chk("pc_no_bubble", id_bubble_a, 32'd0);
    idle();

    // Branch overrides a data-hazard stall.
    id_src1 = 4'd3; id_use_src1 = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; exe_mem_read = 1'b1;
    branch_taken = 1'b1;
    #2;
    chk("br_haz_flush", flush_if_a, 32'd1);
    chk("br_haz_freeze_if", freeze_if_a, 32'd0);
    chk("br_haz_bubble", id_bubble_a, 32'd1);
    tick();
    idle();

    // Memory wait of 5 cycles with a branch in the third, flush in the release cycle.
    do_reset();
    mem_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      branch_taken = (i == 3);
      #2;
      chk("mw_freeze_pipe", freeze_pipe_a, 32'd1);
      chk("mw_freeze_if", freeze_if_a, 32'd1);
      chk("mw_no_flush", flush_if_a, 32'd0);
      tick();
    end
    branch_taken = 1'b0; sram_ready = 1'b1;
    #2;
    chk("mw_rel_freeze_pipe", freeze_pipe_a, 32'd0);
    chk("mw_rel_freeze_if", freeze_if_a, 32'd0);
    chk("mw_rel_flush", flush_if_a, 32'd1);
    chk("mw_rel_bubble", id_bubble_a, 32'd1);
    tick();
    idle();
    #2;
    chk("mw_after_flush", flush_if_a, 32'd0);
    chk("mw_stall_cnt", stall_cycles_a, 32'd5);

    // Branch coinciding with the release cycle flushes once, immediately.
    do_reset();
    mem_req = 1'b1;
    tick();
    sram_ready = 1'b1; branch_taken = 1'b1;
    #2;
    chk("co_flush", flush_if_a, 32'd1);
    chk("co_freeze_pipe", freeze_pipe_a, 32'd0);
    tick();
    idle();
    #2;
    chk("co_no_second_flush", flush_if_a, 32'd0);
    chk("co_stall_cnt", stall_cycles_a, 32'd1);

    // Timeout (dut_b) and counter saturation: 10 frozen cycles.
    do_reset();
    mem_req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      #2;
      chk("to_timeout", mem_timeout_b, 32'(i >= 6));
      chk("to_freeze_pipe", freeze_pipe_b, 32'd1);
      tick();
    end
    #2;
    chk("sat_stall_cnt_b", stall_cycles_b, 32'd7);
    chk("sat_stall_cnt_a", stall_cycles_a, 32'd10);
    chk("to_no_timeout_a", mem_timeout_a, 32'd0);
    sram_ready = 1'b1;
    #1;
    chk("to_sticky", mem_timeout_b, 32'd1);
    chk("to_err_frozen", freeze_pipe_b, 32'd1);
    rst = 1'b0;
    #1;
    chk("to_async_clr_timeout", mem_timeout_b, 32'd0);
    chk("to_async_clr_freeze", freeze_pipe_b, 32'd0);
    chk("to_async_clr_cnt", stall_cycles_b, 32'd0);
    rst = 1'b1;
    tick();
    #2;
    chk("to_after_rst_timeout", mem_timeout_b, 32'd0);
    chk("to_after_rst_freeze", freeze_pipe_b, 32'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
